// File: rtl/pipo_register_pkg.sv
// Shared elaboration helpers for the PIPO register slice.
package pipo_register_pkg;

  // Legal configuration: at least one data bit and at least one register stage.
  function automatic bit params_ok(input int unsigned width, input int unsigned stages);
    return (width >= 1) && (stages >= 1);
  endfunction

endpackage

// File: rtl/pipo_stage.sv
// Single synchronous-reset D register stage of the PIPO chain.
module pipo_stage
  import pipo_register_pkg::*;
#(
  parameter int unsigned           WIDTH       = 4,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (!params_ok(WIDTH, 1)) begin : g_bad_width
    $error("pipo_stage: WIDTH must be >= 1");
  end

  // Load d every edge; reset wins over data.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipo_register.sv
// Parallel-in parallel-out register with STAGES cascaded stages (latency = STAGES edges).
module pipo_register
  import pipo_register_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipo_register: WIDTH and STAGES must both be >= 1");
  end

  // chain[0] is the input word; chain[i+1] is the output of stage i.
  logic [WIDTH-1:0] chain [STAGES+1];

  assign chain[0] = d;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipo_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .d   (chain[g]),
      .q   (chain[g+1])
    );
  end

  // q comes straight from the last stage flops.
  assign q = chain[STAGES];

endmodule

// File: tb/tb_pipo_register.sv
// Scoreboard bench for pipo_register: stimulus pushes the hand-computed q expected after
// each edge; one monitor per instance pops and compares 1 ns after the rising edge.
module tb_pipo_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // a: W4 S1; b: W4 S3; c: W8 S1 reset A5; e: W4 S2 reset 0101
  logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_e = 1'b1;
  logic [3:0] d_a = '0, d_b = '0, d_e = '0;
  logic [7:0] d_c = '0;
  logic [3:0] q_a, q_b, q_e;
  logic [7:0] q_c;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];
  logic [7:0] qe[$];
  int step_a = 0, step_b = 0, step_c = 0, step_e = 0;

  pipo_register u_dut_a (.clk(clk), .rst(rst_a), .d(d_a), .q(q_a));

  pipo_register #(.WIDTH(4), .STAGES(3)) u_dut_b (.clk(clk), .rst(rst_b), .d(d_b), .q(q_b));

  pipo_register #(.WIDTH(8), .STAGES(1), .RESET_VALUE(8'hA5)) u_dut_c (
    .clk(clk), .rst(rst_c), .d(d_c), .q(q_c)
  );

  pipo_register #(.WIDTH(4), .STAGES(2), .RESET_VALUE(4'b0101)) u_dut_e (
    .clk(clk), .rst(rst_e), .d(d_e), .q(q_e)
  );

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: q=%b expected %b at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Drive one vector on the selected instance, record its expected q, advance one cycle.
  task automatic apply(input int sel, input logic r, input logic [7:0] dv,
                       input logic [7:0] e);
    case (sel)
      0: begin rst_a = r; d_a = dv[3:0]; qa.push_back(e); end
      1: begin rst_b = r; d_b = dv[3:0]; qb.push_back(e); end
      2: begin rst_c = r; d_c = dv;      qc.push_back(e); end
      default: begin rst_e = r; d_e = dv[3:0]; qe.push_back(e); end
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitors: compare after every rising edge that has an outstanding expectation.
  initial forever begin
    @(posedge clk); #1;
    if (qa.size() > 0) begin check("w4s1", step_a, {4'b0, q_a}, qa.pop_front()); step_a++; end
    if (qb.size() > 0) begin check("w4s3", step_b, {4'b0, q_b}, qb.pop_front()); step_b++; end
    if (qc.size() > 0) begin check("w8rA5", step_c, q_c, qc.pop_front()); step_c++; end
    if (qe.size() > 0) begin check("w4s2r5", step_e, {4'b0, q_e}, qe.pop_front()); step_e++; end
  end

  initial begin
    // Single-stage: reset, first capture at 15 ns, streaming, hold, reset priority.
    apply(0, 1'b1, 8'h0, 8'h0);
    apply(0, 1'b0, 8'hA, 8'hA);
    apply(0, 1'b0, 8'hC, 8'hC);
    apply(0, 1'b0, 8'hF, 8'hF);
    apply(0, 1'b0, 8'hF, 8'hF);
    apply(0, 1'b0, 8'hF, 8'hF);
    apply(0, 1'b1, 8'h6, 8'h0);
    apply(0, 1'b0, 8'h6, 8'h6);
    apply(0, 1'b0, 8'h8, 8'h8);
    apply(0, 1'b0, 8'h1, 8'h1);

    // Three stages: latency 3, then reset discards in-flight 0100/0101.
    apply(1, 1'b1, 8'h0, 8'h0);
    apply(1, 1'b0, 8'h1, 8'h0);
    apply(1, 1'b0, 8'h2, 8'h0);
    apply(1, 1'b0, 8'h3, 8'h1);
    apply(1, 1'b0, 8'h4, 8'h2);
    apply(1, 1'b0, 8'h5, 8'h3);
    apply(1, 1'b1, 8'hF, 8'h0);
    apply(1, 1'b0, 8'h9, 8'h0);
    apply(1, 1'b0, 8'hA, 8'h0);
    apply(1, 1'b0, 8'hB, 8'h9);
    apply(1, 1'b0, 8'h0, 8'hA);

    // Eight bits, non-zero reset value.
    apply(2, 1'b1, 8'h00, 8'hA5);
    apply(2, 1'b0, 8'hFF, 8'hFF);
    apply(2, 1'b0, 8'h00, 8'h00);
    apply(2, 1'b0, 8'h3C, 8'h3C);
    apply(2, 1'b1, 8'hFF, 8'hA5);
    apply(2, 1'b0, 8'h81, 8'h81);

    // Two stages with reset value 0101: reset value fills both stages.
    apply(3, 1'b1, 8'h0, 8'h5);
    apply(3, 1'b0, 8'hF, 8'h5);
    apply(3, 1'b0, 8'h0, 8'hF);
    apply(3, 1'b0, 8'hF, 8'h0);
    apply(3, 1'b1, 8'h0, 8'h5);
    apply(3, 1'b0, 8'hA, 8'h5);

    #5;
    checks++;
    if (qa.size() + qb.size() + qc.size() + qe.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0",
               qa.size() + qb.size() + qc.size() + qe.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #5000;
    $display("FAIL timeout: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "timeout");
  end

endmodule
